entry_allocator: RTL and testbench

ENTRY_ALLOCATOR -- requirements
Module: entry_allocator

---
 rtl/entry_allocator_pkg.sv | 22 ++
 rtl/entry_allocator_psel.sv | 27 ++
 rtl/entry_allocator.sv | 111 +++++++++++
 tb/tb_entry_allocator.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/entry_allocator_pkg.sv
// Shared allocator definitions: parameter defaults, width helpers and
// port-packing helpers used by the allocator and its selector.
package entry_allocator_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ALLOCS = 2;
  localparam int DEF_FREES  = 2;

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  // LSB of port p's field in a flat bus of w-bit fields
  function automatic int port_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/entry_allocator_psel.sv
// Parallel selector: slot j carries the one-hot of the j-th lowest set bit
// of vec_i (all zeros when fewer than j+1 bits are set).
module psel_gen
  import entry_allocator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REQS  = DEF_ALLOCS
) (
  input  logic [WIDTH-1:0]      vec_i,
  output logic [REQS*WIDTH-1:0] sel_o
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] lsb;

  always_comb begin
    sel_o = '0;
    rem   = vec_i;
    lsb   = '0;
    for (int j = 0; j < REQS; j++) begin
      lsb = rem & (~rem + WIDTH'(1));
      sel_o[port_lsb(j, WIDTH) +: WIDTH] = lsb;
      rem = rem & ~lsb;
    end
  end

endmodule

// File: rtl/entry_allocator.sv
// Free-list allocator: multi-port same-cycle grants from the registered free
// bitmap, multi-port releases with illegal-release detection, and flush.
module entry_allocator
  import entry_allocator_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ALLOCS = DEF_ALLOCS,
  parameter int FREES  = DEF_FREES,
  localparam int IDXW  = idx_w(WIDTH),
  localparam int CNTW  = cnt_w(WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [ALLOCS-1:0]      alloc_req,
  output logic [ALLOCS-1:0]      alloc_gnt,
  output logic [ALLOCS*IDXW-1:0] alloc_idx,
  input  logic [FREES-1:0]       free_valid,
  input  logic [FREES*IDXW-1:0]  free_idx,
  output logic [WIDTH-1:0]       free_vec,
  output logic [CNTW-1:0]        free_cnt,
  output logic                   none_free,
  output logic                   all_free,
  output logic                   err
);

  logic [WIDTH-1:0]        free_vec_q, free_vec_d;
  logic [CNTW-1:0]         free_cnt_q, free_cnt_d;
  logic                    err_q, err_d;
  logic [ALLOCS*WIDTH-1:0] sel;
  logic [WIDTH-1:0]        alloc_mask;
  logic [WIDTH-1:0]        rel_mask;
  logic [IDXW-1:0]         fi;
  int                      rank;

  function automatic logic [IDXW-1:0] oh2idx(input logic [WIDTH-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (oh[b]) idx = idx | IDXW'(b);
    end
    return idx;
  endfunction

  psel_gen #(
    .WIDTH (WIDTH),
    .REQS  (ALLOCS)
  ) u_psel (
    .vec_i (free_vec_q),
    .sel_o (sel)
  );

  // Port k takes selector slot "number of requesting ports below k"
  always_comb begin
    alloc_gnt  = '0;
    alloc_idx  = '0;
    alloc_mask = '0;
    rank       = 0;
    for (int k = 0; k < ALLOCS; k++) begin
      if (alloc_req[k] && !flush && !reset) begin
        if (int'(free_cnt_q) > rank) begin
          alloc_gnt[k] = 1'b1;
          alloc_idx[port_lsb(k, IDXW) +: IDXW] = oh2idx(sel[port_lsb(rank, WIDTH) +: WIDTH]);
          alloc_mask = alloc_mask | sel[port_lsb(rank, WIDTH) +: WIDTH];
        end
        rank = rank + 1;
      end
    end
  end

  // A release is legal only for an entry that is allocated, not granted now,
  // and not already released by a lower port this cycle.
  always_comb begin
    rel_mask = '0;
    err_d    = err_q;
    fi       = '0;
    for (int f = 0; f < FREES; f++) begin
      if (free_valid[f]) begin
        fi = free_idx[port_lsb(f, IDXW) +: IDXW];
        if (free_vec_q[fi] || rel_mask[fi] || alloc_mask[fi]) err_d = 1'b1;
        else rel_mask[fi] = 1'b1;
      end
    end
    free_vec_d = (free_vec_q & ~alloc_mask) | rel_mask;
    free_cnt_d = free_cnt_q - CNTW'($countones(alloc_mask)) + CNTW'($countones(rel_mask));
    if (flush) begin
      free_vec_d = '1;
      free_cnt_d = CNTW'(WIDTH);
      err_d      = err_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_vec_q <= '1;
      free_cnt_q <= CNTW'(WIDTH);
      err_q      <= 1'b0;
    end else begin
      free_vec_q <= free_vec_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end
  end

  assign free_vec  = free_vec_q;
  assign free_cnt  = free_cnt_q;
  assign none_free = (free_cnt_q == '0);
  assign all_free  = (free_cnt_q == CNTW'(WIDTH));
  assign err       = err_q;

endmodule

// File: tb/tb_entry_allocator.sv
// Self-checking bench for entry_allocator (WIDTH=8, ALLOCS=2, FREES=2).
module tb_entry_allocator;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic [1:0] alloc_req, alloc_gnt, free_valid;
  logic [5:0] alloc_idx, free_idx;
  logic [7:0] free_vec;
  logic [3:0] free_cnt;
  logic       none_free, all_free, err;

  typedef struct {
    logic [1:0] gnt;
    logic [2:0] i0;
    logic [2:0] i1;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] mv, mv_n;
  logic       merr, merr_n;
  int         n_chk = 0;
  int         n_fail = 0;

  entry_allocator #(.WIDTH(8), .ALLOCS(2), .FREES(2)) dut (
    .clock(clk), .reset(reset), .flush(flush),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .free_valid(free_valid), .free_idx(free_idx),
    .free_vec(free_vec), .free_cnt(free_cnt),
    .none_free(none_free), .all_free(all_free), .err(err)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, push expected grants, precompute next state
  task automatic step(input logic rs, input logic fl, input logic [1:0] rq,
                      input logic [1:0] fv, input logic [2:0] f0, input logic [2:0] f1);
    exp_t       x;
    logic [7:0] gm, rm;
    logic [2:0] fidx;
    int         j, seen, pick;
    @(negedge clk);
    reset = rs; flush = fl; alloc_req = rq; free_valid = fv; free_idx = {f1, f0};
    x.gnt = 2'b00; x.i0 = 3'd0; x.i1 = 3'd0;
    gm = 8'h00; rm = 8'h00; j = 0;
    for (int k = 0; k < 2; k++) begin
      if (rq[k] && !fl && !rs) begin
        seen = 0; pick = -1;
        for (int b = 0; b < 8; b++) begin
          if (mv[b]) begin
            if (seen == j && pick < 0) pick = b;
            seen++;
          end
        end
        if (pick >= 0) begin
          x.gnt[k] = 1'b1;
          gm[pick] = 1'b1;
          if (k == 0) x.i0 = 3'(pick); else x.i1 = 3'(pick);
        end
        j++;
      end
    end
    sb.push_back(x);
    merr_n = merr;
    for (int f = 0; f < 2; f++) begin
      fidx = (f == 0) ? f0 : f1;
      if (fv[f]) begin
        if (mv[fidx] || rm[fidx] || gm[fidx]) merr_n = 1'b1;
        else rm[fidx] = 1'b1;
      end
    end
    mv_n = (mv & ~gm) | rm;
    if (fl) begin mv_n = 8'hFF; merr_n = merr; end
    if (rs) begin mv_n = 8'hFF; merr_n = 1'b0; end
  endtask

  task automatic tick();
    @(posedge clk);
    mv = mv_n; merr = merr_n;
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 2'b11, 2'b00, 0, 0);
    #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", alloc_gnt); end
    tick();
    n_chk++; if (free_vec !== 8'hFF) begin n_fail++; $display("FAIL reset_vec got %h want ff", free_vec); end
    n_chk++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL reset_cnt got %0d want 8", free_cnt); end
    n_chk++; if ({all_free, none_free, err} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {all_free, none_free, err}); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 2'b11, 2'b00, 0, 0);
      #1; e = sb.pop_front();
      n_chk++; if (alloc_gnt !== 2'b11 || alloc_idx !== {3'(2*c+1), 3'(2*c)})
        begin n_fail++; $display("FAIL fill_gnt c=%0d got %b/%h want 11/%h", c, alloc_gnt, alloc_idx, {3'(2*c+1), 3'(2*c)}); end
      tick();
      if (c == 0) begin
        n_chk++; if (free_vec !== 8'b11111100 || free_cnt !== 4'd6)
          begin n_fail++; $display("FAIL fill_first got %b/%0d want 11111100/6", free_vec, free_cnt); end
      end
    end
    n_chk++; if (free_cnt !== 4'd0 || none_free !== 1'b1 || all_free !== 1'b0)
      begin n_fail++; $display("FAIL fill_empty got cnt %0d nf %b af %b want 0 1 0", free_cnt, none_free, all_free); end
    step(0, 0, 2'b11, 2'b00, 0, 0);
    #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL fill_fifth got %b want 00", alloc_gnt); end
    tick();
  endtask

  task automatic test_single();
    step(0, 0, 2'b00, 2'b01, 3'd0, 3'd0); #1; e = sb.pop_front(); tick();
    n_chk++; if (free_vec !== 8'b00000001) begin n_fail++; $display("FAIL single_vec got %b want 00000001", free_vec); end
    step(0, 0, 2'b11, 2'b00, 0, 0); #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b01 || alloc_idx[2:0] !== 3'd0)
      begin n_fail++; $display("FAIL single_11 got %b idx0 %0d want 01 0", alloc_gnt, alloc_idx[2:0]); end
    tick();
    step(0, 0, 2'b00, 2'b01, 3'd0, 3'd0); #1; e = sb.pop_front(); tick();
    step(0, 0, 2'b10, 2'b00, 0, 0); #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b10 || alloc_idx !== 6'd0)
      begin n_fail++; $display("FAIL single_10 got %b idx %h want 10 00", alloc_gnt, alloc_idx); end
    tick();
  endtask

  task automatic test_no_bypass();
    step(0, 0, 2'b01, 2'b01, 3'd3, 3'd0); #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL nobypass_gnt got %b want 00", alloc_gnt); end
    tick();
    n_chk++; if (free_vec !== 8'b00001000) begin n_fail++; $display("FAIL nobypass_vec got %b want 00001000", free_vec); end
    step(0, 0, 2'b01, 2'b00, 0, 0); #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b01 || alloc_idx[2:0] !== 3'd3)
      begin n_fail++; $display("FAIL nobypass_next got %b idx0 %0d want 01 3", alloc_gnt, alloc_idx[2:0]); end
    tick();
  endtask

  task automatic test_err_flush();
    step(0, 0, 2'b00, 2'b01, 3'd5, 3'd0); #1; e = sb.pop_front(); tick();
    n_chk++; if (err !== 1'b0 || free_cnt !== 4'd1) begin n_fail++; $display("FAIL err_pre got %b/%0d want 0/1", err, free_cnt); end
    step(0, 0, 2'b00, 2'b01, 3'd5, 3'd0); #1; e = sb.pop_front(); tick();
    n_chk++; if (err !== 1'b1 || free_cnt !== 4'd1) begin n_fail++; $display("FAIL err_set got %b/%0d want 1/1", err, free_cnt); end
    step(0, 0, 2'b00, 2'b00, 0, 0); #1; e = sb.pop_front(); tick();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
    step(0, 1, 2'b11, 2'b11, 3'd1, 3'd2); #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL flush_gnt got %b want 00", alloc_gnt); end
    tick();
    n_chk++; if (free_cnt !== 4'd8 || free_vec !== 8'hFF || err !== 1'b1 || all_free !== 1'b1)
      begin n_fail++; $display("FAIL flush_state got %0d/%h/%b/%b want 8/ff/1/1", free_cnt, free_vec, err, all_free); end
  endtask

  task automatic test_reset_priority();
    step(0, 0, 2'b11, 2'b00, 0, 0); #1; e = sb.pop_front(); tick();
    step(1, 1, 2'b11, 2'b11, 3'd0, 3'd1); #1; e = sb.pop_front();
    n_chk++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL rstpri_gnt got %b want 00", alloc_gnt); end
    tick();
    n_chk++; if (free_cnt !== 4'd8 || err !== 1'b0 || free_vec !== 8'hFF)
      begin n_fail++; $display("FAIL rstpri_state got %0d/%b/%h want 8/0/ff", free_cnt, err, free_vec); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 19) == 0), 2'($urandom),
           2'($urandom), 3'($urandom), 3'($urandom));
      #1; e = sb.pop_front();
      n_chk++; if (alloc_gnt !== e.gnt || alloc_idx !== {e.i1, e.i0})
        begin n_fail++; $display("FAIL rand_gnt c=%0d got %b/%h want %b/%h", c, alloc_gnt, alloc_idx, e.gnt, {e.i1, e.i0}); end
      tick();
      n_chk++; if (free_vec !== mv || free_cnt !== 4'($countones(mv)) || err !== merr ||
                   none_free !== (mv == 8'h00) || all_free !== (mv == 8'hFF))
        begin n_fail++; $display("FAIL rand_state c=%0d got %h/%0d/%b want %h/%0d/%b", c, free_vec, free_cnt, err, mv, $countones(mv), merr); end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; alloc_req = '0; free_valid = '0; free_idx = '0;
    mv = 8'hFF; merr = 1'b0; mv_n = 8'hFF; merr_n = 1'b0;
    test_reset();
    test_fill();
    test_single();
    test_no_bypass();
    test_err_flush();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
